// File: rtl/cntry_car_detector_pkg.sv
// Shared constants for the country-road car detector and the signal controller.
// The colour encoding must match the controller's cntry output.
package cntry_car_detector_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESENT   = 2'd2,
    RELEASING = 2'd3
  } det_state_e;

  function automatic logic is_green(input logic [1:0] c);
    return c == GREEN;
  endfunction

endpackage

// File: rtl/cntry_car_detector_loop_debouncer.sv
// Loop sensor front end: two-flop synchroniser plus a 4-state debounce FSM.
// o_arrive and o_occupied describe the transition taken on the coming clock edge.
module loop_debouncer
  import cntry_car_detector_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic clear,
  input  logic i_loop_raw,
  output logic o_arrive,
  output logic o_occupied
);

  localparam logic [3:0] LP_LAST = 4'(DEBOUNCE - 1);

  logic       r_sync1, r_sync2;
  det_state_e r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_sync1 <= i_loop_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ">=" lets DEBOUNCE=1 leave ARMING/RELEASING after a single cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_arrive    = 1'b0;
    case (r_state)
      IDLE: if (r_sync2) begin
        w_state_nxt = ARMING;
        w_cnt_nxt   = 4'd1;
      end
      ARMING: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt >= LP_LAST) begin
          w_state_nxt = PRESENT;
          w_cnt_nxt   = 4'd0;
          o_arrive    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      PRESENT: if (!r_sync2) begin
        w_state_nxt = RELEASING;
        w_cnt_nxt   = 4'd1;
      end
      RELEASING: begin
        if (r_sync2) begin
          w_state_nxt = PRESENT;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt >= LP_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    o_occupied = (w_state_nxt == PRESENT) || (w_state_nxt == RELEASING);
  end

endmodule

// File: rtl/cntry_car_detector.sv
// Car-on-country-road request generator: queues debounced arrivals and retires
// them while the controller shows country GREEN.
module cntry_car_detector
  import cntry_car_detector_pkg::*;
#(
  parameter int DEBOUNCE     = 3,
  parameter int CNT_W        = 4,
  parameter int SERVE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic [1:0]       cntry,
  output logic             x,
  output logic [CNT_W-1:0] queue_count,
  output logic             overflow
);

  localparam logic [3:0] LP_SERVE_LAST = 4'(SERVE_CYCLES - 1);

  logic             w_arrive, w_occ_nxt;
  logic             w_serving, w_retire, w_ovf_set;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [3:0]       r_timer, w_timer_nxt;
  logic             r_x, r_ovf;

  loop_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clock      (clock),
    .clear      (clear),
    .i_loop_raw (loop_raw),
    .o_arrive   (w_arrive),
    .o_occupied (w_occ_nxt)
  );

  assign w_serving = is_green(cntry) && (r_count != '0);
  assign w_retire  = w_serving && (r_timer == LP_SERVE_LAST);

  always_comb begin
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    w_timer_nxt = (w_serving && !w_retire) ? r_timer + 4'd1 : 4'd0;
    // Arrival and retire on the same edge cancel out.
    if (w_arrive && !w_retire) begin
      if (&r_count) w_ovf_set   = 1'b1;
      else          w_count_nxt = r_count + CNT_W'(1);
    end else if (w_retire && !w_arrive) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_count <= '0;
      r_timer <= 4'd0;
      r_ovf   <= 1'b0;
      r_x     <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_timer <= w_timer_nxt;
      r_ovf   <= r_ovf | w_ovf_set;
      r_x     <= (w_count_nxt != '0) || w_occ_nxt;
    end
  end

  assign queue_count = r_count;
  assign overflow    = r_ovf;
  assign x           = r_x;

endmodule
